// File: rtl/proc_pkg.sv
// Shared definitions for the processor datapath and its control FSM:
// register count/index type, F opcodes and the bus-source encoding.
package proc_pkg;

    localparam int NREG = 4;

    typedef logic [1:0] reg_idx_t;

    localparam logic [1:0] LOAD = 2'b00;
    localparam logic [1:0] MOVE = 2'b01;
    localparam logic [1:0] ADD  = 2'b10;
    localparam logic [1:0] SUB  = 2'b11;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_DIN,
        SRC_REG,
        SRC_G
    } bus_src_e;

    // Index of the lowest asserted bit; 0 when none is set.
    function automatic reg_idx_t lowest_idx(input logic [NREG-1:0] v);
        reg_idx_t idx;
        logic     found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (v[i] && !found) begin
                idx   = reg_idx_t'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/proc_alu.sv
// Combinational N-bit add/subtract unit with carry/no-borrow, signed
// overflow and zero flags.
module proc_alu
    import proc_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_addsub,
    output logic [N-1:0] o_res,
    output logic         o_c,
    output logic         o_v,
    output logic         o_z
);

    logic [N-1:0] w_b_eff;
    logic [N:0]   w_sum;

    // Subtract is A + ~B + 1, so the carry-out is the no-borrow flag.
    always_comb begin
        w_b_eff = i_addsub ? i_b : ~i_b;
        w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + {{N{1'b0}}, ~i_addsub};
    end

    assign o_res = w_sum[N-1:0];
    assign o_c   = w_sum[N];
    assign o_v   = (i_a[N-1] == w_b_eff[N-1]) && (w_sum[N-1] != i_a[N-1]);
    assign o_z   = (w_sum[N-1:0] == '0);

endmodule

// File: rtl/proc_datapath.sv
// Shared-bus processor datapath: R0-R3, A, G, add/sub unit, result flags,
// sticky bus-conflict detection and a completed-instruction counter.
module proc_datapath
    import proc_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      DIN,
    input  logic [NREG-1:0]   Rin,
    input  logic [NREG-1:0]   Rout,
    input  logic              Ain,
    input  logic              Gin,
    input  logic              Gout,
    input  logic              addsub,
    input  logic              externx,
    input  logic              Done,
    output logic [N-1:0]      bus,
    output logic [NREG*N-1:0] r_flat,
    output logic [N-1:0]      a_q,
    output logic [N-1:0]      g_q,
    output logic              c_flag,
    output logic              v_flag,
    output logic              z_flag,
    output logic              bus_err,
    output logic [CNT_W-1:0]  op_cnt
);

    logic [N-1:0]     r_reg [NREG];
    logic [N-1:0]     r_a;
    logic [N-1:0]     r_g;
    logic             r_c;
    logic             r_v;
    logic             r_z;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    bus_src_e         w_src;
    reg_idx_t         w_sel;
    logic             w_conflict;
    logic [N-1:0]     w_res;
    logic             w_c;
    logic             w_v;
    logic             w_z;

    // externx with a single Rout bit is a MOVE, so Rout outranks DIN.
    always_comb begin
        w_sel      = lowest_idx(Rout);
        w_conflict = (Gout && (|Rout)) || (|(Rout & (Rout - NREG'(1))));
        if (Gout)
            w_src = SRC_G;
        else if (|Rout)
            w_src = SRC_REG;
        else if (externx)
            w_src = SRC_DIN;
        else
            w_src = SRC_NONE;

        unique case (w_src)
            SRC_G:   bus = r_g;
            SRC_REG: bus = r_reg[w_sel];
            SRC_DIN: bus = DIN;
            default: bus = '0;
        endcase
    end

    proc_alu #(
        .N(N)
    ) u_alu (
        .i_a     (r_a),
        .i_b     (bus),
        .i_addsub(addsub),
        .o_res   (w_res),
        .o_c     (w_c),
        .o_v     (w_v),
        .o_z     (w_z)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++)
                r_reg[i] <= '0;
            r_a   <= '0;
            r_g   <= '0;
            r_c   <= 1'b0;
            r_v   <= 1'b0;
            r_z   <= 1'b0;
            r_err <= 1'b0;
            r_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++)
                if (Rin[i])
                    r_reg[i] <= bus;
            if (Ain)
                r_a <= bus;
            if (Gin) begin
                r_g <= w_res;
                r_c <= w_c;
                r_v <= w_v;
                r_z <= w_z;
            end
            if (w_conflict)
                r_err <= 1'b1;
            if (Done)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        r_flat = '0;
        for (int unsigned i = 0; i < NREG; i++)
            r_flat[i*N +: N] = r_reg[i];
    end

    assign a_q     = r_a;
    assign g_q     = r_g;
    assign c_flag  = r_c;
    assign v_flag  = r_v;
    assign z_flag  = r_z;
    assign bus_err = r_err;
    assign op_cnt  = r_cnt;

endmodule
